// File: rtl/pattern_ctrl.sv
// rtl/pattern_ctrl.sv - pushbutton sync/debounce, mode select and divider limit control
// Optional divider auto-repeat on held pb[8]/pb[11] when PATTERN_CTRL_AUTOREPEAT_EN is defined.
module pattern_ctrl #(
   parameter int DEB_CYCLES    = 3,
   parameter int DIV_RESET     = 2,
   parameter int DIV_MIN       = 1,
   parameter int DIV_MAX       = 20,
   parameter int DIV_STEP      = 2,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_CYCLES = 25
) (
   input  logic        hz100,
   input  logic        reset,
   input  logic [20:0] pb,
   output logic [2:0]  mode,
   output logic [7:0]  divider,
   output logic        mode_chg,
   output logic        div_chg,
   output logic [9:0]  btn_level
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [9:0]    w_pb_used;
   logic [9:0]    r_sync1;
   logic [9:0]    r_sync2;
   logic [CW-1:0] r_deb_cnt [10];
   logic [9:0]    r_level;
   logic [9:0]    r_level_d;
   logic [9:0]    w_press;

   logic [2:0]    r_mode;
   logic [7:0]    r_divider;
   logic          r_mode_chg;
   logic          r_div_chg;

   logic [7:0]    w_mode_ev;
   logic          w_mode_one;
   logic [2:0]    w_mode_idx;
   logic [1:0]    w_rep;
   logic          w_inc;
   logic          w_dec;
   logic [8:0]    w_div_ext;
   logic [8:0]    w_div_up;
   logic [8:0]    w_div_dn;
   logic [8:0]    w_div_next;

   assign w_pb_used = {pb[11], pb[8], pb[7:0]};
   assign w_press   = r_level & ~r_level_d;

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_level_d <= '0;
         for (int i = 0; i < 10; i++) r_deb_cnt[i] <= '0;
      end else begin
         r_sync1   <= w_pb_used;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         for (int i = 0; i < 10; i++) begin
            if (r_sync2[i] == r_level[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
               r_level[i]   <= ~r_level[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef PATTERN_CTRL_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
   localparam int RW      = $clog2(REP_MAX + 1);

   logic [RW-1:0] r_rep_cnt [2];
   logic [1:0]    r_rep_first;
   logic [RW-1:0] w_rep_lim [2];

   // Count edges since the press (or the last repeat); fire on reaching the limit.
   always_comb begin
      w_rep = '0;
      for (int j = 0; j < 2; j++) begin
         w_rep_lim[j] = r_rep_first[j] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_CYCLES - 1);
         w_rep[j]     = r_level[8+j] & ~w_press[8+j] & (r_rep_cnt[j] == w_rep_lim[j]);
      end
   end

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         r_rep_first <= '1;
         for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (!r_level[8+j] || w_press[8+j]) begin
               r_rep_cnt[j]   <= '0;
               r_rep_first[j] <= 1'b1;
            end else if (w_rep[j]) begin
               r_rep_cnt[j]   <= '0;
               r_rep_first[j] <= 1'b0;
            end else begin
               r_rep_cnt[j]   <= r_rep_cnt[j] + 1'b1;
            end
         end
      end
   end
`else
   assign w_rep = 2'b00;
`endif

   assign w_inc = w_press[8] | w_rep[0];
   assign w_dec = w_press[9] | w_rep[1];

   always_comb begin
      w_mode_ev  = w_press[7:0];
      w_mode_one = (w_mode_ev != 8'd0) && ((w_mode_ev & (w_mode_ev - 8'd1)) == 8'd0);
      w_mode_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (w_mode_ev[i]) w_mode_idx = 3'(i);
      end
   end

   // Widened to 9 bits so the clamp sees the true sum before truncation.
   always_comb begin
      w_div_ext = {1'b0, r_divider};
      w_div_up  = w_div_ext + 9'(DIV_STEP);
      if (w_div_up > 9'(DIV_MAX)) w_div_up = 9'(DIV_MAX);
      w_div_dn  = (w_div_ext < 9'(DIV_MIN + DIV_STEP)) ? 9'(DIV_MIN) : (w_div_ext - 9'(DIV_STEP));
      case ({w_inc, w_dec})
         2'b10:   w_div_next = w_div_up;
         2'b01:   w_div_next = w_div_dn;
         default: w_div_next = w_div_ext;
      endcase
   end

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         r_mode     <= 3'd0;
         r_divider  <= 8'(DIV_RESET);
         r_mode_chg <= 1'b0;
         r_div_chg  <= 1'b0;
      end else begin
         r_mode_chg <= w_mode_one;
         if (w_mode_one) r_mode <= w_mode_idx;
         r_div_chg  <= (w_div_next[7:0] != r_divider);
         r_divider  <= w_div_next[7:0];
      end
   end

   assign mode      = r_mode;
   assign divider   = r_divider;
   assign mode_chg  = r_mode_chg;
   assign div_chg   = r_div_chg;
   assign btn_level = r_level;

endmodule
